// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request bus: fetch side is master, memory side is slave.
// A beat transfers when mem_req & mem_ready; req/addr hold steady until then.
interface if_fetch_ctrl_if #(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32
);
   logic               mem_req;
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_ready;
   logic [INSTR_W-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ready,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ready,
      output mem_rdata
   );
endinterface

// File: rtl/if_fetch_ctrl.sv
// IF fetch sequencer: 1-cycle memory-to-IF/ID latency, stalls absorbed by a 1-entry skid, EXE branches redirect.
// Backpressure: mem_ready low holds req/addr; hazard_stall freezes outputs. FETCH_PERF_EN adds perf counters.
module if_fetch_ctrl #(
   parameter int                ADDR_W   = 32,
   parameter int                INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               hazard_stall,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_addr,
   if_fetch_ctrl_if.master    mem,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        perf_wait_cnt,
   output logic [31:0]        perf_flush_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

   state_t             state;
   logic [ADDR_W-1:0]  fetch_addr;
   logic [ADDR_W-1:0]  next_addr;
   logic               skid_vld;
   logic [INSTR_W-1:0] skid_instr;
   logic [ADDR_W-1:0]  skid_pc;
   logic               xfer;

   assign xfer      = mem.mem_req & mem.mem_ready;
   assign next_addr = fetch_addr + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         fetch_addr   <= RESET_PC;
         mem.mem_req  <= 1'b0;
         mem.mem_addr <= RESET_PC;
         if_valid     <= 1'b0;
         if_instr     <= '0;
         if_pc        <= '0;
         skid_vld     <= 1'b0;
         skid_instr   <= '0;
         skid_pc      <= '0;
      end else begin
         case (state)
            IDLE: begin
               state       <= REQ;
               mem.mem_req <= 1'b1;
               if (branch_taken) begin
                  fetch_addr   <= branch_addr;
                  mem.mem_addr <= branch_addr;
               end else begin
                  mem.mem_addr <= fetch_addr;
               end
            end

            REQ: begin
               if (branch_taken) begin
                  if_valid   <= 1'b0;
                  skid_vld   <= 1'b0;
                  fetch_addr <= branch_addr;
                  // An un-returned request must still complete at its old address.
                  if (xfer) mem.mem_addr <= branch_addr;
                  else      state        <= DRAIN;
               end else if (xfer) begin
                  fetch_addr   <= next_addr;
                  mem.mem_addr <= next_addr;
                  if (hazard_stall) begin
                     skid_vld    <= 1'b1;
                     skid_instr  <= mem.mem_rdata;
                     skid_pc     <= next_addr;
                     mem.mem_req <= 1'b0;
                     state       <= HOLD;
                  end else begin
                     if_instr <= mem.mem_rdata;
                     if_pc    <= next_addr;
                     if_valid <= 1'b1;
                  end
               end else if (!hazard_stall) begin
                  if_valid <= 1'b0;
               end
            end

            HOLD: begin
               if (branch_taken) begin
                  if_valid     <= 1'b0;
                  skid_vld     <= 1'b0;
                  fetch_addr   <= branch_addr;
                  mem.mem_addr <= branch_addr;
                  mem.mem_req  <= 1'b1;
                  state        <= REQ;
               end else if (!hazard_stall) begin
                  if_instr    <= skid_instr;
                  if_pc       <= skid_pc;
                  if_valid    <= skid_vld;
                  skid_vld    <= 1'b0;
                  mem.mem_req <= 1'b1;
                  state       <= REQ;
               end
            end

            DRAIN: begin
               if_valid <= 1'b0;
               skid_vld <= 1'b0;
               if (branch_taken) fetch_addr <= branch_addr;
               if (xfer) begin
                  state        <= REQ;
                  mem.mem_addr <= branch_taken ? branch_addr : fetch_addr;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_wait_cnt  <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (mem.mem_req && !mem.mem_ready && perf_wait_cnt != 32'hFFFF_FFFF)
            perf_wait_cnt <= perf_wait_cnt + 32'd1;
         if (branch_taken && perf_flush_cnt != 32'hFFFF_FFFF)
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl; memory returns {16'hC0DE, addr[15:0]} for any address.
module tb_if_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        hazard_stall;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        ready;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_wait_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   int total = 0;
   int bad   = 0;

   if_fetch_ctrl_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

   assign bus.mem_ready = ready;
   assign bus.mem_rdata = {16'hC0DE, bus.mem_addr[15:0]};

   if_fetch_ctrl #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
      .clk          (clk),
      .rst          (rst),
      .hazard_stall (hazard_stall),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .mem          (bus.master),
      .if_valid     (if_valid),
      .if_instr     (if_instr),
      .if_pc        (if_pc)
`ifdef FETCH_PERF_EN
      ,
      .perf_wait_cnt  (perf_wait_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                          input logic vld, input logic [31:0] pc);
      chk({tag, ".mem_req"},  {31'b0, bus.mem_req}, {31'b0, req});
      chk({tag, ".mem_addr"}, bus.mem_addr, addr);
      chk({tag, ".if_valid"}, {31'b0, if_valid}, {31'b0, vld});
      chk({tag, ".if_pc"},    if_pc, pc);
   endtask

   initial begin
      rst          = 1'b0;
      hazard_stall = 1'b0;
      branch_taken = 1'b0;
      branch_addr  = 32'h0;
      ready        = 1'b1;
      step();
      chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0);
      chk("reset.if_instr", if_instr, 32'h0);
      step();
      rst = 1'b1;

      // Streaming with ready tied high
      step(); chk_out("e1", 1'b1, 32'd0, 1'b0, 32'd0);
      step(); chk_out("e2", 1'b1, 32'd1, 1'b1, 32'd1);
      chk("e2.if_instr", if_instr, 32'hC0DE_0000);
      step(); chk_out("e3", 1'b1, 32'd2, 1'b1, 32'd2);
      step(); chk_out("e4", 1'b1, 32'd3, 1'b1, 32'd3);
      step(); chk_out("e5", 1'b1, 32'd4, 1'b1, 32'd4);
      step(); chk_out("e6", 1'b1, 32'd5, 1'b1, 32'd5);

      // Memory wait at addr 5
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(); chk_out("wait5", 1'b1, 32'd5, 1'b0, 32'd5);
      end
`ifdef FETCH_PERF_EN
      chk("perf.wait3", perf_wait_cnt, 32'd3);
`endif
      ready = 1'b1;
      step(); chk_out("e10", 1'b1, 32'd6, 1'b1, 32'd6);
      chk("e10.if_instr", if_instr, 32'hC0DE_0005);
      step(); chk_out("e11", 1'b1, 32'd7, 1'b1, 32'd7);
      step(); chk_out("e12", 1'b1, 32'd8, 1'b1, 32'd8);

      // Hazard stall catching the addr-8 transfer into the skid
      hazard_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(); chk_out("hold", 1'b0, 32'd9, 1'b1, 32'd8);
         chk("hold.if_instr", if_instr, 32'hC0DE_0007);
      end
      hazard_stall = 1'b0;
      step(); chk_out("unhold", 1'b1, 32'd9, 1'b1, 32'd9);
      chk("unhold.if_instr", if_instr, 32'hC0DE_0008);
      step(); chk_out("e18", 1'b1, 32'd10, 1'b1, 32'd10);
      step(); chk_out("e19", 1'b1, 32'd11, 1'b1, 32'd11);
      step(); chk_out("e20", 1'b1, 32'd12, 1'b1, 32'd12);

      // Branch while addr 12 is outstanding
      ready        = 1'b0;
      branch_taken = 1'b1;
      branch_addr  = 32'h40;
      step(); chk_out("drain1", 1'b1, 32'd12, 1'b0, 32'd12);
      branch_taken = 1'b0;
      step(); chk_out("drain2", 1'b1, 32'd12, 1'b0, 32'd12);
      ready = 1'b1;
      step(); chk_out("redir", 1'b1, 32'h40, 1'b0, 32'd12);
      step(); chk_out("tgt", 1'b1, 32'h41, 1'b1, 32'h41);
      chk("tgt.if_instr", if_instr, 32'hC0DE_0040);

      // Branch and stall together with the skid full
      hazard_stall = 1'b1;
      step(); chk_out("skid", 1'b0, 32'h42, 1'b1, 32'h41);
      branch_taken = 1'b1;
      branch_addr  = 32'h80;
      step(); chk_out("brhold", 1'b1, 32'h80, 1'b0, 32'h41);
`ifdef FETCH_PERF_EN
      chk("perf.flush2", perf_flush_cnt, 32'd2);
`endif
      branch_taken = 1'b0;
      hazard_stall = 1'b0;
      step(); chk_out("postskid", 1'b1, 32'h81, 1'b1, 32'h81);
      chk("postskid.if_instr", if_instr, 32'hC0DE_0080);

      // Branch with a same-cycle transfer, then address wrap
      branch_taken = 1'b1;
      branch_addr  = 32'hFFFF_FFFF;
      step(); chk_out("brxfer", 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h81);
      branch_taken = 1'b0;
      step(); chk_out("wrap", 1'b1, 32'h0, 1'b1, 32'h0);
      chk("wrap.if_instr", if_instr, 32'hC0DE_FFFF);

      // Two branches while draining; the later target wins
      ready        = 1'b0;
      branch_taken = 1'b1;
      branch_addr  = 32'h20;
      step(); chk_out("dbl1", 1'b1, 32'h0, 1'b0, 32'h0);
      branch_addr = 32'h30;
      step(); chk_out("dbl2", 1'b1, 32'h0, 1'b0, 32'h0);
      branch_taken = 1'b0;
      ready        = 1'b1;
      step(); chk_out("dbl3", 1'b1, 32'h30, 1'b0, 32'h0);
`ifdef FETCH_PERF_EN
      chk("perf.wait", perf_wait_cnt, 32'd7);
      chk("perf.flush", perf_flush_cnt, 32'd5);
`endif

      // Asynchronous reset with a request outstanding
      ready = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk_out("arst", 1'b0, 32'h0, 1'b0, 32'h0);
      chk("arst.if_instr", if_instr, 32'h0);
      step();
      rst   = 1'b1;
      ready = 1'b1;
      step(); chk_out("rerun", 1'b1, 32'h0, 1'b0, 32'h0);
      step(); chk_out("rerun2", 1'b1, 32'h1, 1'b1, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Fetch sequencer for the IF stage.
- Owns the fetch address and drives a variable-latency instruction memory through a req/ready handshake.
- Absorbs hazard stalls with a 1-entry skid buffer and redirects on taken branches from EXE.
- Presents {if_valid, if_instr, if_pc} to the IF/ID register; PC is word-addressed (increments by 1).

Parameters:
- ADDR_W, 32, fetch address / PC width
- INSTR_W, 32, instruction width
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- hazard_stall  in  1  hold IF/ID outputs (from hazard unit)
- branch_taken  in  1  redirect request from EXE, single-cycle pulse
- branch_addr  in  ADDR_W  redirect target, valid with branch_taken
- mem_req  out  1  memory request
- mem_addr  out  ADDR_W  request address (= fetch_addr)
- mem_ready  in  1  memory accepts/returns; transfer = mem_req & mem_ready
- mem_rdata  in  INSTR_W  instruction, valid in the transfer cycle
- if_valid  out  1  if_instr/if_pc hold a live instruction
- if_instr  out  INSTR_W  fetched instruction
- if_pc  out  ADDR_W  address of fetched instruction + 1

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, fetch_addr=RESET_PC, mem_req=0, if_valid=0, if_instr=0, if_pc=0, skid empty.
- IDLE:
  - mem_req=0.
  - First clock after reset release -> REQ.
- REQ:
  - mem_req=1, mem_addr=fetch_addr.
  - Transfer, no stall, no branch: if_instr<=mem_rdata, if_pc<=fetch_addr+1, if_valid<=1, fetch_addr<=fetch_addr+1; stay REQ.
  - No transfer, no stall: if_valid<=0 (bubble).
  - Transfer with hazard_stall=1: data -> skid {instr, fetch_addr+1}, fetch_addr+=1, outputs hold -> HOLD.
  - No transfer with stall: outputs hold, request continues.
- HOLD:
  - mem_req=0; outputs hold while hazard_stall=1.
  - Stall drops: outputs <= skid, if_valid<=1, skid empties -> REQ.
- DRAIN:
  - mem_req=1 at the old address (must not change until ready).
  - On transfer, data is discarded -> REQ at the latched target.
  - if_valid=0 throughout.
- Handshake rules:
  - Once mem_req is asserted, mem_req and mem_addr are stable until a transfer.
  - mem_ready without mem_req is ignored.
- branch_taken has priority over hazard_stall in every state:
  - if_valid<=0, skid cleared, fetch_addr<=branch_addr.
  - In REQ without transfer that cycle -> DRAIN (old request completes). With transfer that cycle -> data dropped -> REQ.
  - In HOLD or IDLE -> REQ.
  - Second branch_taken while in DRAIN -> target overwritten, stay DRAIN.
- Address arithmetic: fetch_addr+1 wraps modulo 2^ADDR_W; no fault.
- Reset asserted mid-transfer: immediate return to reset values; no pending state survives.

Optional Feature:
- Macro: FETCH_PERF_EN
- Defined:
  - Adds output ports perf_wait_cnt[31:0] (cycles with mem_req=1 & mem_ready=0) and perf_flush_cnt[31:0] (accepted branch_taken pulses).
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, mem_ready tied 1, RESET_PC=0 -> mem_addr 0,1,2,3 on consecutive cycles; if_pc 1,2,3 one cycle behind; if_valid=1 from the 2nd post-reset cycle.
- mem_ready low 3 cycles at addr 5 -> mem_req/mem_addr=5 stable; if_valid=0 for those cycles; then if_instr=mem[5], if_pc=6.
- hazard_stall=1 for 4 cycles during a transfer at addr 8 -> outputs frozen at the prior instruction; mem_req=0 in HOLD; after release if_instr=mem[8], if_pc=9, next mem_addr=9.
- branch_taken, branch_addr=0x40, while addr 12 is outstanding (ready arrives 2 cycles later) -> mem_addr stays 12 until ready; data discarded; next mem_addr=0x40; if_valid=0 until mem[0x40] arrives.
- branch_taken and hazard_stall in the same cycle, skid full -> skid cleared, if_valid=0, next mem_addr=branch_addr.
- fetch_addr=0xFFFFFFFF transfer -> if_pc=0, next mem_addr=0. With FETCH_PERF_EN, 3 wait cycles and 2 branches -> perf_wait_cnt=3, perf_flush_cnt=2.
